// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared types and defaults for the Sobel edge-detect pipeline
//               (sobel_window_gen feeding sobel_filter).
//               - pixel_t     : one pixel
//               - window_t    : 3x3 neighbourhood, element 0 top-left,
//                               element 8 bottom-right
//               - win_state_e : window generator sequencing states
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    // Frame geometry shared by the window generator and the filter.
    localparam int SOBEL_IMG_WIDTH  = 128;
    localparam int SOBEL_IMG_HEIGHT = 128;
    localparam int SOBEL_PIX_W      = 8;

    typedef logic [SOBEL_PIX_W-1:0] pixel_t;
    typedef pixel_t [8:0]           window_t;

    // Explicit 2-bit encoding so the state register width is fixed.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } win_state_e;

endpackage
`default_nettype wire

// File: rtl/sobel_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One image row of pixel storage. Simple dual-port RAM with a
//               single write port and a single registered read port. A read
//               and a write to the same address in the same cycle return the
//               old contents (read-before-write). The storage is not reset.
// Ports       : clk      - clock, rising edge
//               wr_en    - write enable
//               wr_addr  - write column
//               wr_data  - pixel to store
//               rd_addr  - read column, sampled every cycle
//               rd_data  - registered read data (mem[rd_addr] of last edge)
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = SOBEL_IMG_WIDTH,
    parameter int PIX_W  = SOBEL_PIX_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rd_data;

    // Non-blocking update gives read-before-write ordering naturally.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen
// Description : Converts a raster-order pixel stream into 3x3 neighbourhood
//               windows, one per interior pixel of the frame. Two line
//               buffers hold the previous two rows; a 3x3 register array is
//               shifted one column per accepted pixel once row 2 is reached.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous reset, active low
//               pixel_in    - input pixel, raster order
//               pixel_valid - pixel_in accepted on this edge (no backpressure)
//               sof         - start of frame, qualified by pixel_valid
//               win_flat    - window, element k at [k*PIX_W +: PIX_W]
//               win_valid   - win_flat/win_row/win_col updated this cycle
//               win_row     - row of the window centre pixel
//               win_col     - column of the window centre pixel
//               frame_done  - one-cycle pulse after the last window
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
    parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT,
    parameter int PIX_W      = SOBEL_PIX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIX_W-1:0]              pixel_in,
    input  logic                          pixel_valid,
    input  logic                          sof,
    output logic [9*PIX_W-1:0]            win_flat,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          frame_done
);

    localparam int c_ROW_W = $clog2(IMG_HEIGHT);
    localparam int c_COL_W = $clog2(IMG_WIDTH);

    localparam logic [c_COL_W-1:0] c_LAST_COL      = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW      = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_FILL_ROW = c_ROW_W'(1);
    localparam logic [c_COL_W-1:0] c_FIRST_WIN_COL = c_COL_W'(2);
    localparam logic [c_COL_W-1:0] c_COL_ONE       = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE       = c_ROW_W'(1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    win_state_e             r_state;
    win_state_e             w_state_next;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_ROW_W-1:0]     w_row_next;
    logic [c_COL_W-1:0]     r_col;
    logic [c_COL_W-1:0]     w_col_next;

    // 3x3 shift array, index = row*3 + col (row 0 = oldest image row).
    logic [PIX_W-1:0]       r_win      [9];
    logic [PIX_W-1:0]       w_win_next [9];
    logic [9*PIX_W-1:0]     w_win_next_flat;

    logic [9*PIX_W-1:0]     r_win_flat;
    logic                   r_win_valid;
    logic [c_ROW_W-1:0]     r_win_row;
    logic [c_COL_W-1:0]     r_win_col;
    logic                   r_frame_done;

    logic [PIX_W-1:0]       w_lb0_rd;
    logic [PIX_W-1:0]       w_lb1_rd;
    logic [c_COL_W-1:0]     w_wr_addr;

    logic                   w_in_frame;
    logic                   w_start;
    logic                   w_adv;
    logic                   w_eol;
    logic                   w_lb_we;
    logic                   w_shift;
    logic                   w_emit;

    // ------------------------------------------------------------------------
    // Acceptance qualifiers
    // ------------------------------------------------------------------------
    // A sof pixel always (re)starts a frame at (0,0), whatever the state.
    // A non-sof pixel only advances the frame while one is in progress.
    assign w_in_frame = (r_state == FILL) || (r_state == STREAM);
    assign w_start    = pixel_valid && sof;
    assign w_adv      = pixel_valid && !sof && w_in_frame;
    assign w_eol      = (r_col == c_LAST_COL);
    assign w_lb_we    = w_start || w_adv;
    assign w_wr_addr  = w_start ? '0 : r_col;
    assign w_shift    = w_adv && (r_state == STREAM);
    // Columns 0 and 1 of a row leave stale data from the previous row in the
    // left of the shift array; only from column 2 is the window complete.
    assign w_emit     = w_shift && (r_col >= c_FIRST_WIN_COL);

    // ------------------------------------------------------------------------
    // State and position sequencing
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;

        if (w_start) begin
            // The sof pixel itself occupies (0,0); the next one is (0,1).
            w_state_next = FILL;
            w_row_next   = '0;
            w_col_next   = c_COL_ONE;
        end else if (w_adv) begin
            if (w_eol) begin
                w_col_next = '0;
                w_row_next = r_row + c_ROW_ONE;
            end else begin
                w_col_next = r_col + c_COL_ONE;
            end

            if ((r_state == FILL) && w_eol && (r_row == c_LAST_FILL_ROW)) begin
                w_state_next = STREAM;
            end

            if ((r_state == STREAM) && w_eol && (r_row == c_LAST_ROW)) begin
                w_state_next = DONE;
                w_row_next   = '0;
                w_col_next   = '0;
            end
        end else if (r_state == DONE) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------------
    // lb0 holds the previous row, lb1 the row before that. The read address
    // is the column of the next pixel to arrive, so the registered read data
    // is already waiting when that pixel is accepted, even after gaps.
    line_buffer #(
        .DEPTH   (IMG_WIDTH),
        .PIX_W   (PIX_W),
        .ADDR_W  (c_COL_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .wr_addr (w_wr_addr),
        .wr_data (pixel_in),
        .rd_addr (w_col_next),
        .rd_data (w_lb0_rd)
    );

    // The old lb0 entry moves down into lb1 as the new pixel replaces it.
    line_buffer #(
        .DEPTH   (IMG_WIDTH),
        .PIX_W   (PIX_W),
        .ADDR_W  (c_COL_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .wr_addr (w_wr_addr),
        .wr_data (w_lb0_rd),
        .rd_addr (w_col_next),
        .rd_data (w_lb1_rd)
    );

    // ------------------------------------------------------------------------
    // Window shift: left by one column, new right column from the buffers
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win_next[3*i]     = r_win[3*i + 1];
            w_win_next[3*i + 1] = r_win[3*i + 2];
            w_win_next[3*i + 2] = r_win[3*i + 2];
        end
        w_win_next[2] = w_lb1_rd;
        w_win_next[5] = w_lb0_rd;
        w_win_next[8] = pixel_in;
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign w_win_next_flat[k*PIX_W +: PIX_W] = w_win_next[k];
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
            r_win_flat   <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;

            if (w_shift) begin
                for (int k = 0; k < 9; k++) begin
                    r_win[k] <= w_win_next[k];
                end
            end

            // Window outputs hold between emissions; only valid pulses.
            r_win_valid <= w_emit;
            if (w_emit) begin
                r_win_flat <= w_win_next_flat;
                r_win_row  <= r_row - c_ROW_ONE;
                r_win_col  <= r_col - c_COL_ONE;
            end

            // DONE is entered on the edge that accepts the last pixel, so
            // this pulse lands the cycle after the final win_valid.
            r_frame_done <= (r_state == DONE);
        end
    end

    assign win_flat   = r_win_flat;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_gen
// Description : Self-checking bench for sobel_window_gen. A 4x4 instance
//               covers sequencing corner cases; a 128x128 instance streams
//               two back-to-back ramp frames. Expected windows are queued as
//               pixels are driven and compared as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4x4 instance
    logic [7:0]  a_pix;
    logic        a_valid;
    logic        a_sof;
    logic [71:0] a_win;
    logic        a_wv;
    logic [1:0]  a_row;
    logic [1:0]  a_col;
    logic        a_fd;

    // 128x128 instance
    logic [7:0]  b_pix;
    logic        b_valid;
    logic        b_sof;
    logic [71:0] b_win;
    logic        b_wv;
    logic [6:0]  b_row;
    logic [6:0]  b_col;
    logic        b_fd;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (a_pix),
        .pixel_valid (a_valid),
        .sof         (a_sof),
        .win_flat    (a_win),
        .win_valid   (a_wv),
        .win_row     (a_row),
        .win_col     (a_col),
        .frame_done  (a_fd)
    );

    sobel_window_gen #(.IMG_WIDTH(128), .IMG_HEIGHT(128), .PIX_W(8)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (b_pix),
        .pixel_valid (b_valid),
        .sof         (b_sof),
        .win_flat    (b_win),
        .win_valid   (b_wv),
        .win_row     (b_row),
        .win_col     (b_col),
        .frame_done  (b_fd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model for the 4x4 instance: keeps the frame image and emits
    // the window around (r-1,c-1) when (r,c) with r,c >= 2 is received.
    // ------------------------------------------------------------------------
    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  img_a [4][4];
    bit          m_act = 0;
    int          m_r   = 0;
    int          m_c   = 0;

    task automatic model_a(input logic [7:0] v, input logic s);
        exp_t e;
        if (s) begin
            m_act = 1;
            m_r   = 0;
            m_c   = 0;
        end else if (!m_act) begin
            return;
        end
        img_a[m_r][m_c] = v;
        if (m_r >= 2 && m_c >= 2) begin
            for (int k = 0; k < 9; k++) begin
                e.win[k*8 +: 8] = img_a[m_r - 2 + k/3][m_c - 2 + k%3];
            end
            e.row = m_r - 1;
            e.col = m_c - 1;
            qa.push_back(e);
        end
        m_c++;
        if (m_c == 4) begin
            m_c = 0;
            m_r++;
            if (m_r == 4) m_act = 0;
        end
    endtask

    task automatic send_a(input logic [7:0] v, input logic s);
        a_pix   = v;
        a_sof   = s;
        a_valid = 1'b1;
        model_a(v, s);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_sof   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Output monitors (sample on the falling edge)
    // ------------------------------------------------------------------------
    int          a_wcnt  = 0;
    int          a_fdcnt = 0;
    bit          a_gap   = 0;
    logic        a_prev_wv = 1'b0;
    logic [71:0] a_first_win = '0;

    always @(negedge clk) begin
        exp_t e;
        if (a_wv === 1'b1) begin
            a_wcnt++;
            if (a_wcnt == 1) a_first_win = a_win;
            if (a_gap) check_eq("a_win_back_to_back", 128'(a_prev_wv), 128'(0));
            check_eq("a_win_expected", 128'(qa.size() != 0), 128'(1));
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check_eq("a_win_data", 128'(a_win), 128'(e.win));
                check_eq("a_win_row", 128'(a_row), 128'(e.row));
                check_eq("a_win_col", 128'(a_col), 128'(e.col));
            end
        end
        if (a_fd === 1'b1) begin
            a_fdcnt++;
            check_eq("a_fd_after_last_win", 128'(a_prev_wv), 128'(1));
            check_eq("a_fd_queue_empty", 128'(qa.size()), 128'(0));
        end
        a_prev_wv = a_wv;
    end

    int   b_wcnt  = 0;
    int   b_fdcnt = 0;
    logic b_prev_wv = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (b_wv === 1'b1) begin
            b_wcnt++;
            check_eq("b_win_expected", 128'(qb.size() != 0), 128'(1));
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check_eq("b_win", 128'({b_win, b_row, b_col}), 128'({e.win, 7'(e.row), 7'(e.col)}));
            end
        end
        if (b_fd === 1'b1) begin
            b_fdcnt++;
            check_eq("b_frame_win_count", 128'(b_wcnt), 128'(15876));
            check_eq("b_fd_after_last_win", 128'(b_prev_wv), 128'(1));
            b_wcnt = 0;
        end
        b_prev_wv = b_wv;
    end

    localparam logic [71:0] c_FIRST_RAMP = 72'h0a0908_060504_020100;
    localparam logic [71:0] c_FIRST_100  = 72'h6e6d6c_6a6968_666564;

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        a_pix = '0; a_valid = 1'b0; a_sof = 1'b0;
        b_pix = '0; b_valid = 1'b0; b_sof = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check_eq("rst_a_win_valid", 128'(a_wv), 128'(0));
        check_eq("rst_a_win_flat", 128'(a_win), 128'(0));
        check_eq("rst_a_win_pos", 128'({a_row, a_col}), 128'(0));
        check_eq("rst_a_frame_done", 128'(a_fd), 128'(0));
        check_eq("rst_b_outputs", 128'({b_wv, b_fd, b_row, b_col}), 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(1);

        // Continuous 4x4 ramp
        a_wcnt = 0; a_fdcnt = 0;
        for (int i = 0; i < 16; i++) send_a(8'(i), 1'(i == 0));
        idle_cycles(5);
        check_eq("s1_win_count", 128'(a_wcnt), 128'(4));
        check_eq("s1_frame_done", 128'(a_fdcnt), 128'(1));
        check_eq("s1_first_win", 128'(a_first_win), 128'(c_FIRST_RAMP));
        check_eq("s1_queue_empty", 128'(qa.size()), 128'(0));

        // Same frame with valid toggling
        a_wcnt = 0; a_fdcnt = 0; a_gap = 1;
        for (int i = 0; i < 16; i++) begin
            send_a(8'(i), 1'(i == 0));
            idle_cycles(1);
        end
        idle_cycles(5);
        a_gap = 0;
        check_eq("gap_win_count", 128'(a_wcnt), 128'(4));
        check_eq("gap_frame_done", 128'(a_fdcnt), 128'(1));
        check_eq("gap_first_win", 128'(a_first_win), 128'(c_FIRST_RAMP));

        // Pixels in IDLE without sof are dropped
        a_wcnt = 0; a_fdcnt = 0;
        for (int i = 0; i < 6; i++) send_a(8'(50 + i), 1'b0);
        idle_cycles(5);
        check_eq("idle_win_count", 128'(a_wcnt), 128'(0));
        check_eq("idle_frame_done", 128'(a_fdcnt), 128'(0));

        // sof reasserted at pixel 9, then a fresh ramp from 100
        a_wcnt = 0; a_fdcnt = 0;
        for (int i = 0; i < 9; i++) send_a(8'(i), 1'(i == 0));
        for (int i = 0; i < 16; i++) send_a(8'(100 + i), 1'(i == 0));
        idle_cycles(5);
        check_eq("resof_win_count", 128'(a_wcnt), 128'(4));
        check_eq("resof_frame_done", 128'(a_fdcnt), 128'(1));
        check_eq("resof_first_win", 128'(a_first_win), 128'(c_FIRST_100));
        check_eq("resof_queue_empty", 128'(qa.size()), 128'(0));

        // Asynchronous reset mid-STREAM
        a_wcnt = 0; a_fdcnt = 0;
        for (int i = 0; i < 12; i++) send_a(8'(i), 1'(i == 0));
        @(negedge clk);
        #2;
        check_eq("prerst_win_count", 128'(a_wcnt), 128'(2));
        check_eq("prerst_win_valid", 128'(a_wv), 128'(1));
        rst = 1'b0;
        #1;
        check_eq("midrst_win_valid", 128'(a_wv), 128'(0));
        check_eq("midrst_win_flat", 128'(a_win), 128'(0));
        check_eq("midrst_win_pos", 128'({a_row, a_col}), 128'(0));
        check_eq("midrst_frame_done", 128'(a_fd), 128'(0));
        qa.delete();
        m_act = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(1);
        a_wcnt = 0; a_fdcnt = 0;
        for (int i = 0; i < 16; i++) send_a(8'(i), 1'(i == 0));
        idle_cycles(5);
        check_eq("postrst_win_count", 128'(a_wcnt), 128'(4));
        check_eq("postrst_frame_done", 128'(a_fdcnt), 128'(1));
        check_eq("postrst_first_win", 128'(a_first_win), 128'(c_FIRST_RAMP));
        check_eq("postrst_queue_empty", 128'(qa.size()), 128'(0));

        // Two back-to-back 128x128 frames, value = (r+c) mod 256
        b_wcnt = 0; b_fdcnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 128; r++) begin
                for (int c = 0; c < 128; c++) begin
                    b_pix   = 8'((r + c) % 256);
                    b_sof   = 1'(r == 0 && c == 0);
                    b_valid = 1'b1;
                    if (r >= 2 && c >= 2) begin
                        for (int k = 0; k < 9; k++) begin
                            e.win[k*8 +: 8] = 8'(((r - 2 + k/3) + (c - 2 + k%3)) % 256);
                        end
                        e.row = r - 1;
                        e.col = c - 1;
                        qb.push_back(e);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        b_valid = 1'b0;
        b_sof   = 1'b0;
        idle_cycles(6);
        check_eq("b_frame_done_count", 128'(b_fdcnt), 128'(2));
        check_eq("b_queue_empty", 128'(qb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
